// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line memories plus a 3x3 column shift window.
// Optional start-of-frame resync port enabled by defining WIN_SOF_EN.
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
`ifdef WIN_SOF_EN
  input  logic              in_sof,
`endif
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] p00,
  output logic [DATA_W-1:0] p01,
  output logic [DATA_W-1:0] p02,
  output logic [DATA_W-1:0] p10,
  output logic [DATA_W-1:0] p11,
  output logic [DATA_W-1:0] p12,
  output logic [DATA_W-1:0] p20,
  output logic [DATA_W-1:0] p21,
  output logic [DATA_W-1:0] p22
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic             sof_hit;
  logic             emit;
  logic             out_valid_q;

  logic [DATA_W-1:0] line1 [IMG_W];
  logic [DATA_W-1:0] line2 [IMG_W];
  logic [DATA_W-1:0] rd1, rd2;

  // win_q[row][col]: row 0 is the oldest line, col 2 the newest column.
  logic [2:0][2:0][DATA_W-1:0] win_q;

`ifdef WIN_SOF_EN
  assign sof_hit = in_valid & in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    col_cur = sof_hit ? '0 : col_q;
    row_cur = sof_hit ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + COL_W'(1);
        row_d = row_cur;
      end
    end
    emit = in_valid && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
  end

  assign rd1 = line1[col_cur];
  assign rd2 = line2[col_cur];

  // NOTE: line memories are deliberately not reset; the row>=2 gate keeps their stale contents from ever being emitted.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line2[col_cur] <= rd1;
      line1[col_cur] <= in_pixel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= emit;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= rd2;
        win_q[1][2] <= rd1;
        win_q[2][2] <= in_pixel;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p00 = win_q[0][0];
  assign p01 = win_q[0][1];
  assign p02 = win_q[0][2];
  assign p10 = win_q[1][0];
  assign p11 = win_q[1][1];
  assign p12 = win_q[1][2];
  assign p20 = win_q[2][0];
  assign p21 = win_q[2][1];
  assign p22 = win_q[2][2];

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen: two instances (4x3 and 7x5) fed the same stream,
// each compared against a frame-image reference model.
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int NW = 2;
  localparam int WA = 4, HA = 3;
  localparam int WB = 7, HB = 5;
  localparam int WIN_BITS = 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_pixel = '0;
`ifdef WIN_SOF_EN
  logic          in_sof = 1'b0;
`endif

  logic          ov [NW];
  logic [DW-1:0] pa [9];
  logic [DW-1:0] pb [9];
  logic [WIN_BITS-1:0] obs [NW];

  always #5 clk = ~clk;

  window3x3_gen #(.DATA_W(DW), .IMG_W(WA), .IMG_H(HA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef WIN_SOF_EN
    .in_sof(in_sof),
`endif
    .in_pixel(in_pixel), .out_valid(ov[0]),
    .p00(pa[0]), .p01(pa[1]), .p02(pa[2]),
    .p10(pa[3]), .p11(pa[4]), .p12(pa[5]),
    .p20(pa[6]), .p21(pa[7]), .p22(pa[8])
  );

  window3x3_gen #(.DATA_W(DW), .IMG_W(WB), .IMG_H(HB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef WIN_SOF_EN
    .in_sof(in_sof),
`endif
    .in_pixel(in_pixel), .out_valid(ov[1]),
    .p00(pb[0]), .p01(pb[1]), .p02(pb[2]),
    .p10(pb[3]), .p11(pb[4]), .p12(pb[5]),
    .p20(pb[6]), .p21(pb[7]), .p22(pb[8])
  );

  assign obs[0] = {pa[0], pa[1], pa[2], pa[3], pa[4], pa[5], pa[6], pa[7], pa[8]};
  assign obs[1] = {pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7], pb[8]};

  // Reference model: the current frame as a flat image plus the raster index of the next pixel.
  logic [DW-1:0]       img [NW][64];
  int                  k [NW];
  int                  pulses [NW];
  int                  exp_pulses [NW];
  logic [WIN_BITS-1:0] last_win [NW];
  bit                  hold_ok [NW];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int wd(int d);
    return (d == 0) ? WA : WB;
  endfunction

  function automatic int ht(int d);
    return (d == 0) ? HA : HB;
  endfunction

  function automatic logic [WIN_BITS-1:0] win_exp(int d, int r, int c);
    logic [WIN_BITS-1:0] e;
    e = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e = {e[WIN_BITS-DW-1:0], img[d][(r - 2 + i) * wd(d) + (c - 2 + j)]};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WIN_BITS-1:0] o, input logic [WIN_BITS-1:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NW; d++) begin
      k[d]        = 0;
      hold_ok[d]  = 1'b1;
      last_win[d] = '0;
    end
  endtask

  task automatic clear_pulses();
    for (int d = 0; d < NW; d++) begin
      pulses[d]     = 0;
      exp_pulses[d] = 0;
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] pix, input bit sof);
    int r, c;
    logic [WIN_BITS-1:0] e;
    in_valid = v;
    in_pixel = pix;
`ifdef WIN_SOF_EN
    in_sof = sof;
`endif
    @(posedge clk);
    #1;
    for (int d = 0; d < NW; d++) begin
      if (v) begin
`ifdef WIN_SOF_EN
        if (sof) k[d] = 0;
`endif
        img[d][k[d]] = pix;
        r = k[d] / wd(d);
        c = k[d] % wd(d);
        if (r >= 2 && c >= 2) begin
          e = win_exp(d, r, c);
          chk($sformatf("valid_hi d%0d r%0d c%0d", d, r, c), WIN_BITS'(ov[d]), WIN_BITS'(1));
          chk($sformatf("window d%0d r%0d c%0d", d, r, c), obs[d], e);
          last_win[d] = e;
          hold_ok[d]  = 1'b1;
          exp_pulses[d]++;
        end else begin
          chk($sformatf("valid_lo d%0d r%0d c%0d", d, r, c), WIN_BITS'(ov[d]), WIN_BITS'(0));
          hold_ok[d] = 1'b0;
        end
        k[d] = (k[d] + 1) % (wd(d) * ht(d));
      end else begin
        chk($sformatf("idle_valid d%0d", d), WIN_BITS'(ov[d]), WIN_BITS'(0));
        if (hold_ok[d]) chk($sformatf("idle_hold d%0d", d), obs[d], last_win[d]);
      end
      if (ov[d] === 1'b1) pulses[d]++;
    end
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int d = 0; d < NW; d++) begin
      chk($sformatf("%s rst_valid d%0d", tag, d), WIN_BITS'(ov[d]), WIN_BITS'(0));
      chk($sformatf("%s rst_win d%0d", tag, d), obs[d], '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_pulses(input string tag, input int want_a);
    chk({tag, " pulses_a"}, WIN_BITS'(pulses[0]), WIN_BITS'(want_a));
    chk({tag, " pulses_a_model"}, WIN_BITS'(pulses[0]), WIN_BITS'(exp_pulses[0]));
    chk({tag, " pulses_b_model"}, WIN_BITS'(pulses[1]), WIN_BITS'(exp_pulses[1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_pulses();
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Back-to-back frame 0..11
    clear_pulses();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 10) chk("t1_first_win", obs[0], {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
      if (i == 11) chk("t1_second_win", obs[0], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
    end
    step(1'b0, '0, 1'b0);
    check_pulses("t1", 2);

    // Same frame with three idle cycles between pixels
    clear_pulses();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 11) chk("t2_second_win", obs[0], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      repeat (3) step(1'b0, '0, 1'b0);
    end
    check_pulses("t2", 2);

    // Two consecutive frames 0..23
    do_reset("t3");
    clear_pulses();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 22) chk("t3_f2_first_win", obs[0], {8'd12, 8'd13, 8'd14, 8'd16, 8'd17, 8'd18, 8'd20, 8'd21, 8'd22});
    end
    step(1'b0, '0, 1'b0);
    check_pulses("t3", 4);

    // Mid-frame reset after pixel 6, then a fresh frame
    do_reset("t4a");
    for (int i = 0; i < 7; i++) step(1'b1, DW'(i), 1'b0);
    do_reset("t4");
    clear_pulses();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(50 + i), 1'b0);
      if (i == 10) chk("t4_first_win", obs[0], {8'd50, 8'd51, 8'd52, 8'd54, 8'd55, 8'd56, 8'd58, 8'd59, 8'd60});
    end
    step(1'b0, '0, 1'b0);
    check_pulses("t4", 2);

`ifdef WIN_SOF_EN
    // Start-of-frame resync mid-row
    do_reset("t5");
    clear_pulses();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(200 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, DW'(100), 1'b1);
    for (int i = 1; i < 12; i++) begin
      step(1'b1, DW'(100 + i), 1'b0);
      if (i == 10) chk("t5_first_win", obs[0], {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110});
      if (i == 11) chk("t5_second_win", obs[0], {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111});
    end
    step(1'b0, '0, 1'b0);
    check_pulses("t5", 2);
`endif

    // Random pixels with random idle gaps across several frames of both instances
    do_reset("t6");
    clear_pulses();
    for (int i = 0; i < 4 * WB * HB; i++) begin
      if ($urandom_range(3) == 0) step(1'b0, DW'($urandom), 1'b0);
      step(1'b1, DW'($urandom), 1'b0);
    end
    step(1'b0, '0, 1'b0);
    check_pulses("t6", 2 * ((4 * WB * HB) / (WA * HA)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
